// File: rtl/jtcontra_dwnld_pkg.sv
// Shared definitions for the Contra ROM download loader.
// Holds the byte-address map of the ROM set, the region classification
// used by the decoder and the entry format stored in the write buffer.
package jtcontra_dwnld_pkg;

    localparam logic [24:0] SND_START  = 25'h02_0000;
    localparam logic [24:0] GFX1_START = 25'h02_8000;
    localparam logic [24:0] GFX2_START = 25'h0A_8000;
    localparam logic [24:0] PROM_START = 25'h12_8000;
    localparam logic [24:0] PROM_END   = PROM_START + 25'h400;

    typedef enum logic [1:0] {
        MAIN_SND = 2'd0,
        GFX      = 2'd1,
        PROM     = 2'd2,
        NONE     = 2'd3
    } region_t;

    typedef struct packed {
        region_t     tag;
        logic [21:0] addr;
        logic [7:0]  data;
        logic        lane;
    } entry_t;

    function automatic region_t region_of(input logic [24:0] a);
        if (a < GFX1_START)      return MAIN_SND;
        else if (a < PROM_START) return GFX;
        else if (a < PROM_END)   return PROM;
        else                     return NONE;
    endfunction

endpackage

// File: rtl/jtcontra_dwnld_fifo.sv
// Two-deep synchronous FIFO for decoded download entries.
// Ports: clk, rst (sync, active high), push/din write side,
// pop/dout read side (dout is the current head, valid when !empty),
// full/empty status. A push while full is accepted only if a pop
// happens in the same cycle.
module jtcontra_dwnld_fifo
    import jtcontra_dwnld_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/jtcontra_dwnld.sv
// Contra ROM download loader.
// Turns the framework byte stream (ioctl_*) into SDRAM byte writes
// (prog_addr word address, prog_data, active-low prog_mask, prog_we held
// until sdram_ack) and one-cycle prom_we strobes for the colour PROMs.
// GFX bytes are reordered so each 16-bit SDRAM word holds bytes n and n+2.
// Ports: clk, rst (sync, active high), downloading, ioctl_addr/data/wr in;
// prog_addr/data/mask/we, prom_we, dwnld_busy, overflow out; sdram_ack in.
//
//  state   | meaning
//  IDLE    | waiting for a buffered entry; pops and issues it
//  WAIT    | SDRAM request on prog_we, waiting for sdram_ack
//  GAP     | one idle cycle after ack before the next request
module jtcontra_dwnld
    import jtcontra_dwnld_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        sdram_ack,
    output logic        prom_we,
    output logic        dwnld_busy,
    output logic        overflow
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

    state_t      state, state_nx;
    region_t     region;
    entry_t      entry_in, head;
    logic [24:0] gfx_off, prom_off;
    logic [21:0] gfx_base;
    logic        push, pop, full, empty;
    logic        downloading_d;
    logic [21:0] prog_addr_nx;
    logic [7:0]  prog_data_nx;
    logic [1:0]  prog_mask_nx;
    logic        prog_we_nx, prom_we_nx;
    logic        decode_unused;

    // decode
    assign region   = region_of(ioctl_addr);
    assign gfx_base = (ioctl_addr < GFX2_START) ? GFX1_START[22:1] : GFX2_START[22:1];
    assign gfx_off  = ioctl_addr - ((ioctl_addr < GFX2_START) ? GFX1_START : GFX2_START);
    assign prom_off = ioctl_addr - PROM_START;
    assign decode_unused = ^{gfx_off[24:19], prom_off[24:10]};

    always_comb begin
        entry_in      = '0;
        entry_in.tag  = region;
        entry_in.data = ioctl_data;
        case (region)
            MAIN_SND: begin
                entry_in.addr = ioctl_addr[22:1];
                entry_in.lane = ioctl_addr[0];
            end
            GFX: begin
                // bytes 0,2 share a word, bytes 1,3 the next one
                entry_in.addr = gfx_base + {4'd0, gfx_off[18:2], gfx_off[0]};
                entry_in.lane = gfx_off[1];
            end
            PROM: begin
                entry_in.addr = {12'd0, prom_off[9:0]};
            end
            default: ;
        endcase
    end

    assign push = downloading & ioctl_wr & (region != NONE);

    jtcontra_dwnld_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (entry_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // output FSM
    always_comb begin
        state_nx     = state;
        prog_addr_nx = prog_addr;
        prog_data_nx = prog_data;
        prog_mask_nx = prog_mask;
        prog_we_nx   = prog_we;
        prom_we_nx   = 1'b0;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    prog_addr_nx = head.addr;
                    prog_data_nx = head.data;
                    if (head.tag == PROM) begin
                        prom_we_nx = 1'b1;
                    end else begin
                        prog_mask_nx = head.lane ? 2'b01 : 2'b10;
                        prog_we_nx   = 1'b1;
                        state_nx     = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (sdram_ack) begin
                    prog_we_nx = 1'b0;
                    state_nx   = ST_GAP;
                end
            end
            ST_GAP:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
            prog_we   <= 1'b0;
            prom_we   <= 1'b0;
        end else begin
            state     <= state_nx;
            prog_addr <= prog_addr_nx;
            prog_data <= prog_data_nx;
            prog_mask <= prog_mask_nx;
            prog_we   <= prog_we_nx;
            prom_we   <= prom_we_nx;
        end
    end

    // overflow: cleared when a new window opens, a drop in that same cycle still wins
    always_ff @(posedge clk) begin
        if (rst) begin
            downloading_d <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            downloading_d <= downloading;
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (downloading && !downloading_d)
                overflow <= 1'b0;
        end
    end

    assign dwnld_busy = downloading | ~empty | (state != ST_IDLE);

endmodule

// File: tb/tb_jtcontra_dwnld.sv
module tb_jtcontra_dwnld;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        sdram_ack = 1'b0;
    logic        prom_we;
    logic        dwnld_busy;
    logic        overflow;

    logic auto_ack = 1'b0;
    logic manual_ack = 1'b0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic        is_prom;
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } rec_t;
    rec_t q[$];

    jtcontra_dwnld dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .sdram_ack   (sdram_ack),
        .prom_we     (prom_we),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // ack driver and write monitor; a request is logged when it will be accepted at the next edge
    always @(negedge clk) begin
        sdram_ack = auto_ack ? prog_we : manual_ack;
        if (!rst && prog_we && sdram_ack) q.push_back('{1'b0, prog_addr, prog_data, prog_mask});
        if (!rst && prom_we)              q.push_back('{1'b1, prog_addr, prog_data, prog_mask});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic chk_rec(input string tag, input int i, input logic is_prom,
                           input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
        if (i < q.size()) begin
            check({tag, "_kind"}, {31'd0, q[i].is_prom}, {31'd0, is_prom});
            check({tag, "_addr"}, {10'd0, q[i].addr}, {10'd0, a});
            check({tag, "_data"}, {24'd0, q[i].data}, {24'd0, d});
            check({tag, "_mask"}, {30'd0, q[i].mask}, {30'd0, m});
        end else begin
            check({tag, "_missing"}, q.size(), i + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset
        tick(); tick();
        rst = 1'b0;
        check("rst_prog_we", {31'd0, prog_we}, 0);
        check("rst_prom_we", {31'd0, prom_we}, 0);
        check("rst_addr", {10'd0, prog_addr}, 0);
        check("rst_data", {24'd0, prog_data}, 0);
        check("rst_mask", {30'd0, prog_mask}, 32'h3);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_busy", {31'd0, dwnld_busy}, 0);

        // main byte, manual ack three cycles after request
        downloading = 1'b1;
        tick();
        wr_byte(25'h00003, 8'h5A);
        check("main_lat1_we", {31'd0, prog_we}, 0);
        tick();
        check("main_lat2_we", {31'd0, prog_we}, 1);
        check("main_addr", {10'd0, prog_addr}, 32'h1);
        check("main_mask", {30'd0, prog_mask}, 32'h1);
        check("main_data", {24'd0, prog_data}, 32'h5A);
        tick(); tick();
        check("main_hold_we", {31'd0, prog_we}, 1);
        manual_ack = 1'b1;
        tick();
        manual_ack = 1'b0;
        check("main_we_drop", {31'd0, prog_we}, 0);
        repeat (3) tick();
        check("main_count", q.size(), 1);
        q.delete();

        // GFX reorder plus GFX2 and sound-region bytes, auto ack
        auto_ack = 1'b1;
        wr_byte(25'h28000, 8'h11); repeat (4) tick();
        wr_byte(25'h28001, 8'h22); repeat (4) tick();
        wr_byte(25'h28002, 8'h33); repeat (4) tick();
        wr_byte(25'h28003, 8'h44); repeat (4) tick();
        wr_byte(25'hA8003, 8'h55); repeat (4) tick();
        wr_byte(25'h20001, 8'h66); repeat (6) tick();
        check("gfx_count", q.size(), 6);
        chk_rec("gfx0", 0, 1'b0, 22'h14000, 8'h11, 2'b10);
        chk_rec("gfx1", 1, 1'b0, 22'h14001, 8'h22, 2'b10);
        chk_rec("gfx2", 2, 1'b0, 22'h14000, 8'h33, 2'b01);
        chk_rec("gfx3", 3, 1'b0, 22'h14001, 8'h44, 2'b01);
        chk_rec("gfx2b", 4, 1'b0, 22'h54001, 8'h55, 2'b01);
        chk_rec("snd", 5, 1'b0, 22'h10000, 8'h66, 2'b01);
        q.delete();

        // PROM strobe (mask left as the last SDRAM write set it), then out-of-map byte
        wr_byte(25'h128005, 8'h07);
        repeat (5) tick();
        wr_byte(25'h128400, 8'h99);
        repeat (5) tick();
        check("prom_count", q.size(), 1);
        chk_rec("prom", 0, 1'b1, 22'h5, 8'h07, 2'b01);
        check("prom_no_ovf", {31'd0, overflow}, 0);
        q.delete();

        // overflow with ack held low
        auto_ack = 1'b0;
        ioctl_wr = 1'b1;
        ioctl_addr = 25'h10; ioctl_data = 8'hA1; tick();
        ioctl_addr = 25'h11; ioctl_data = 8'hA2; tick();
        ioctl_addr = 25'h12; ioctl_data = 8'hA3; tick();
        ioctl_addr = 25'h13; ioctl_data = 8'hA4; tick();
        ioctl_wr = 1'b0;
        check("ovf_set", {31'd0, overflow}, 1);
        check("ovf_head_we", {31'd0, prog_we}, 1);
        check("ovf_head_addr", {10'd0, prog_addr}, 32'h8);
        check("ovf_head_data", {24'd0, prog_data}, 32'hA1);
        manual_ack = 1'b1;
        repeat (12) tick();
        manual_ack = 1'b0;
        check("ovf_count", q.size(), 3);
        chk_rec("ovf0", 0, 1'b0, 22'h8, 8'hA1, 2'b10);
        chk_rec("ovf1", 1, 1'b0, 22'h8, 8'hA2, 2'b01);
        chk_rec("ovf2", 2, 1'b0, 22'h9, 8'hA3, 2'b10);
        check("ovf_sticky", {31'd0, overflow}, 1);
        downloading = 1'b0;
        tick();
        downloading = 1'b1;
        tick();
        check("ovf_clear", {31'd0, overflow}, 0);
        q.delete();

        // tail drain after downloading falls
        ioctl_wr = 1'b1;
        ioctl_addr = 25'h20; ioctl_data = 8'hB1; tick();
        ioctl_addr = 25'h21; ioctl_data = 8'hB2; tick();
        ioctl_addr = 25'h22; ioctl_data = 8'hB3; tick();
        ioctl_wr = 1'b0;
        downloading = 1'b0;
        wr_byte(25'h24, 8'hEE);
        check("tail_busy", {31'd0, dwnld_busy}, 1);
        manual_ack = 1'b1;
        for (int i = 0; i < 30 && q.size() < 3; i++) tick();
        check("tail_drained", q.size(), 3);
        check("tail_gap_busy", {31'd0, dwnld_busy}, 1);
        check("tail_gap_we", {31'd0, prog_we}, 0);
        tick();
        check("tail_idle_busy", {31'd0, dwnld_busy}, 0);
        manual_ack = 1'b0;
        repeat (4) tick();
        check("tail_count", q.size(), 3);
        chk_rec("tail0", 0, 1'b0, 22'h10, 8'hB1, 2'b10);
        chk_rec("tail1", 1, 1'b0, 22'h10, 8'hB2, 2'b01);
        chk_rec("tail2", 2, 1'b0, 22'h11, 8'hB3, 2'b10);
        q.delete();

        // reset during WAIT with one more entry buffered
        downloading = 1'b1;
        tick();
        ioctl_wr = 1'b1;
        ioctl_addr = 25'h30; ioctl_data = 8'hC1; tick();
        ioctl_addr = 25'h31; ioctl_data = 8'hC2; tick();
        ioctl_wr = 1'b0;
        check("rw_we_before", {31'd0, prog_we}, 1);
        rst = 1'b1;
        downloading = 1'b0;
        tick();
        rst = 1'b0;
        check("rw_we", {31'd0, prog_we}, 0);
        check("rw_busy", {31'd0, dwnld_busy}, 0);
        check("rw_mask", {30'd0, prog_mask}, 32'h3);
        check("rw_addr", {10'd0, prog_addr}, 0);
        manual_ack = 1'b1;
        repeat (5) tick();
        manual_ack = 1'b0;
        check("rw_we_late", {31'd0, prog_we}, 0);
        check("rw_busy_late", {31'd0, dwnld_busy}, 0);
        check("rw_count", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
